// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: shared FSM state, digit index type and special segment codes for alu_result_display.
package alu_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
endpackage

// File: rtl/alu_result_display_seg7_decoder.sv
// seg7_decoder: 4-bit BCD to active-low {g,f,e,d,c,b,a}; 10..15 decode to blank.
module seg7_decoder import alu_disp_pkg::*; (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/alu_result_display.sv
// alu_result_display: captures a signed ALU result, converts it to sign + 2 BCD digits, scans a 4-digit 7-seg display.
// Optional macro ALU_DISP_ZERO_BLANK_EN blanks a leading zero tens digit.
module alu_result_display import alu_disp_pkg::*; #(
  parameter int WIDTH       = 6,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] RES,
  input  logic             OF,
  output logic             READY,
  output logic [WIDTH-1:0] HOLD,
  output logic [3:0]       AN,
  output logic [6:0]       SEG,
  output logic             DP
);
  localparam int SW = $clog2(WIDTH + 1);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  state_t state, state_n;
  logic of_q, sign_q, of_c, sign_c, last_step, wrap, zero_blank;
  logic [WIDTH-1:0] bin, mag;
  logic [7:0] bcd, bcd_adj, bcd_c;
  logic [SW-1:0] step;
  logic [CW-1:0] scan;
  digit_idx_t idx;
  logic [3:0] digit;
  logic [6:0] dec, seg_n;
  assign READY = state == IDLE;
  assign DP = 1'b1;
  assign last_step = step == SW'(WIDTH - 1);
  assign mag = RES[WIDTH-1] ? ~RES + WIDTH'(1) : RES;
  assign bcd_adj = {bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4],
                    bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0]};
  always_ff @(posedge CLK)
    state <= RST ? IDLE : state_n;
  always_comb begin
    state_n = LOAD ? CONV : state == CONV && last_step ? COMMIT : state == COMMIT ? IDLE : state;
  end
  // LOAD always wins so a new result restarts a conversion in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      HOLD <= '0;
      of_q <= 1'b0;
      sign_q <= 1'b0;
      bin <= '0;
      bcd <= '0;
      step <= '0;
      bcd_c <= '0;
      sign_c <= 1'b0;
      of_c <= 1'b0;
    end else if (LOAD) begin
      HOLD <= RES;
      of_q <= OF;
      sign_q <= RES[WIDTH-1];
      bin <= mag;
      bcd <= '0;
      step <= '0;
    end else if (state == CONV) begin
      bcd <= {bcd_adj[6:0], bin[WIDTH-1]};
      bin <= bin << 1;
      step <= step + SW'(1);
    end else if (state == COMMIT) begin
      bcd_c <= bcd;
      sign_c <= sign_q;
      of_c <= of_q;
    end
  end
`ifdef ALU_DISP_ZERO_BLANK_EN
  assign zero_blank = bcd_c[7:4] == 4'd0;
`else
  assign zero_blank = 1'b0;
`endif
  assign digit = idx == 2'd0 ? bcd_c[3:0] : idx == 2'd1 && !zero_blank ? bcd_c[7:4] : 4'hF;
  seg7_decoder u_dec (.digit(digit), .seg(dec));
  assign seg_n = of_c ? (idx == 2'd0 ? SEG_F : idx == 2'd1 ? SEG_O : SEG_BLANK)
               : idx == 2'd3 && sign_c ? SEG_MINUS : dec;
  assign wrap = scan == CW'(REFRESH_DIV - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan <= '0;
      idx <= '0;
      AN <= 4'hF;
      SEG <= SEG_BLANK;
    end else begin
      scan <= wrap ? '0 : scan + CW'(1);
      idx <= wrap ? idx + 2'd1 : idx;
      AN <= ~(4'b0001 << idx);
      SEG <= seg_n;
    end
  end
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: directed self-checking bench for alu_result_display with REFRESH_DIV=4.
module tb_alu_result_display;
  logic CLK = 1'b0, RST = 1'b1, LOAD = 1'b0, OF = 1'b0;
  logic [5:0] RES = '0;
  logic READY, DP;
  logic [5:0] HOLD;
  logic [3:0] AN;
  logic [6:0] SEG;
  int n_checks = 0, n_fail = 0;
  logic watch = 1'b0, seen7 = 1'b0;
  localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;
`ifdef ALU_DISP_ZERO_BLANK_EN
  localparam logic [6:0] TENS0 = 7'b1111111;
`else
  localparam logic [6:0] TENS0 = 7'b1000000;
`endif
  alu_result_display #(.WIDTH(6), .REFRESH_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .RES(RES), .OF(OF),
    .READY(READY), .HOLD(HOLD), .AN(AN), .SEG(SEG), .DP(DP)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK)
    if (watch && AN == 4'b1110 && SEG == 7'b1111000) seen7 = 1'b1;
  task automatic read_digits(output logic [6:0] got [4]);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] want;
      bit found;
      want = 4'b1111 ^ (4'b0001 << d);
      found = 0;
      got[d] = 'x;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge CLK);
        if (AN === want) begin
          got[d] = SEG;
          found = 1;
        end
      end
      if (!found) begin
        n_checks++;
        n_fail++;
        $display("FAIL scan_timeout digit %0d: AN=%b never reached %b", d, AN, want);
      end
    end
  endtask
  task automatic load_start(input logic [5:0] r, input logic o);
    @(negedge CLK);
    RES = r;
    OF = o;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask
  task automatic count_ready(output int n);
    n = 0;
    while (READY === 1'b0 && n < 20) begin
      n++;
      @(negedge CLK);
    end
  endtask
  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks += 5;
    if (AN !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", AN); end
    if (SEG !== BL) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", SEG, BL); end
    if (READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", READY); end
    if (HOLD !== 6'd0) begin n_fail++; $display("FAIL reset_hold: got %b expected 000000", HOLD); end
    if (DP !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", DP); end
    RST = 1'b0;
    @(negedge CLK);
    n_checks += 2;
    if (AN !== 4'b1110) begin n_fail++; $display("FAIL release_an: got %b expected 1110", AN); end
    if (SEG !== 7'b1000000) begin n_fail++; $display("FAIL release_seg: got %b expected 1000000", SEG); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (AN !== 4'b1110) begin n_fail++; $display("FAIL scan_hold_an: got %b expected 1110", AN); end
    @(negedge CLK);
    n_checks++;
    if (AN !== 4'b1101) begin n_fail++; $display("FAIL scan_step_an: got %b expected 1101", AN); end
  endtask
  task automatic run_case(input string name, input logic [5:0] r, input logic o,
                          input logic [6:0] e3, input logic [6:0] e1, input logic [6:0] e0);
    int n;
    logic [6:0] got [4];
    logic [6:0] exp [4];
    load_start(r, o);
    count_ready(n);
    n_checks += 2;
    if (n !== 7) begin n_fail++; $display("FAIL %s_ready_low: got %0d cycles expected 7", name, n); end
    if (HOLD !== r) begin n_fail++; $display("FAIL %s_hold: got %b expected %b", name, HOLD, r); end
    exp = '{e0, e1, BL, e3};
    read_digits(got);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (got[d] !== exp[d]) begin
        n_fail++;
        $display("FAIL %s_digit%0d: got %b expected %b", name, d, got[d], exp[d]);
      end
    end
  endtask
  task automatic test_neg3;
    run_case("neg3", 6'b111101, 1'b0, MI, TENS0, 7'b0110000);
  endtask
  task automatic test_neg32;
    run_case("neg32", 6'b100000, 1'b0, MI, 7'b0110000, 7'b0100100);
  endtask
  task automatic test_overflow;
    run_case("overflow", 6'd5, 1'b1, BL, 7'b1000000, 7'b0001110);
  endtask
  task automatic test_zero_blank;
    run_case("seven", 6'd7, 1'b0, BL, TENS0, 7'b1111000);
  endtask
  task automatic test_restart;
    int n;
    logic [6:0] got [4];
    logic [6:0] exp [4];
    watch = 1'b1;
    load_start(6'd7, 1'b0);
    @(negedge CLK);
    load_start(6'd31, 1'b0);
    count_ready(n);
    n_checks += 2;
    if (n !== 7) begin n_fail++; $display("FAIL restart_ready_low: got %0d cycles expected 7", n); end
    if (HOLD !== 6'd31) begin n_fail++; $display("FAIL restart_hold: got %0d expected 31", HOLD); end
    exp = '{7'b1111001, 7'b0110000, BL, BL};
    read_digits(got);
    watch = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (got[d] !== exp[d]) begin
        n_fail++;
        $display("FAIL restart_digit%0d: got %b expected %b", d, got[d], exp[d]);
      end
    end
    n_checks++;
    if (seen7 !== 1'b0) begin n_fail++; $display("FAIL restart_no_07: got seen7=%b expected 0", seen7); end
  endtask
  task automatic test_rst_in_conv;
    logic [6:0] got [4];
    logic [6:0] exp [4];
    load_start(6'd13, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_checks += 4;
    if (READY !== 1'b1) begin n_fail++; $display("FAIL rstconv_ready: got %b expected 1", READY); end
    if (AN !== 4'b1111) begin n_fail++; $display("FAIL rstconv_an: got %b expected 1111", AN); end
    if (SEG !== BL) begin n_fail++; $display("FAIL rstconv_seg: got %b expected %b", SEG, BL); end
    if (HOLD !== 6'd0) begin n_fail++; $display("FAIL rstconv_hold: got %b expected 000000", HOLD); end
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    n_checks++;
    if (READY !== 1'b1) begin n_fail++; $display("FAIL rstconv_ready_after: got %b expected 1", READY); end
    exp = '{7'b1000000, TENS0, BL, BL};
    read_digits(got);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (got[d] !== exp[d]) begin
        n_fail++;
        $display("FAIL rstconv_digit%0d: got %b expected %b", d, got[d], exp[d]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_neg3();
    test_neg32();
    test_overflow();
    test_restart();
    test_zero_blank();
    test_rst_in_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
